// File: rtl/cla_addsub_seq_pkg.sv
// cla_addsub_seq_pkg: shared FSM encoding and configuration check for the sliced add/sub sequencer.
package cla_addsub_seq_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic bit cfg_ok(input int data_w, input int slice_w);
        return (slice_w > 0) && (data_w % slice_w == 0) && (data_w / slice_w >= 2);
    endfunction

endpackage

// File: rtl/cla_slice_addsub.sv
// cla_slice_addsub: combinational SLICE_W-bit carry-lookahead adder exposing carry-out and carry into MSB.
module cla_slice_addsub #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               co_o,
    output logic               cm_o
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    // Each carry is a flat sum of products over generate/propagate terms below it, no chain.
    always_comb begin
        logic [SLICE_W-1:0] w_mi;
        logic [SLICE_W-1:0] w_mj;
        w_c    = '0;
        w_mi   = '0;
        w_mj   = '0;
        w_c[0] = c_i;
        for (int i = 0; i < SLICE_W; i++) begin
            w_mi     = {SLICE_W{1'b1}} >> (SLICE_W - 1 - i);
            w_c[i+1] = c_i & (&(w_p | ~w_mi));
            for (int j = 0; j <= i; j++) begin
                w_mj     = w_mi & ~({SLICE_W{1'b1}} >> (SLICE_W - 1 - j));
                w_c[i+1] = w_c[i+1] | (w_g[j] & (&(w_p | ~w_mj)));
            end
        end
    end

    assign s_o  = w_p ^ w_c[SLICE_W-1:0];
    assign co_o = w_c[SLICE_W];
    assign cm_o = w_c[SLICE_W-1];

endmodule

// File: rtl/cla_addsub_seq.sv
// cla_addsub_seq: wide signed add/subtract computed LSB-slice first through one shared CLA slice,
// with valid/ready handshakes on request and result.
module cla_addsub_seq
    import cla_addsub_seq_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o,
    output logic              ovf_o,
    output logic              busy_o
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W      = $clog2(NUM_SLICES);

    if (!cfg_ok(DATA_W, SLICE_W)) begin : g_cfg_err
        $error("cla_addsub_seq: DATA_W must be a multiple of SLICE_W with at least two slices");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_c;
    logic [DATA_W-1:0]  r_sum;
    logic               r_out_valid;
    logic               r_carry;
    logic               r_ovf;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;
    logic               w_cm;

    cla_slice_addsub #(.SLICE_W(SLICE_W)) u_slice (
        .a_i (r_a[r_idx*SLICE_W +: SLICE_W]),
        .b_i (r_b[r_idx*SLICE_W +: SLICE_W]),
        .c_i (r_c),
        .s_o (w_s),
        .co_o(w_co),
        .cm_o(w_cm)
    );

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as the first carry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid_i) begin
                    r_a     <= a_i;
                    r_b     <= b_i ^ {DATA_W{sub_i}};
                    r_c     <= sub_i;
                    r_idx   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
                    r_c   <= w_co;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_SLICES - 1)) begin
                        r_carry     <= w_co;
                        r_ovf       <= w_cm ^ w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (out_ready_i) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = r_state == IDLE;
    assign busy_o      = r_state != IDLE;
    assign out_valid_o = r_out_valid;
    assign sum_o       = r_sum;
    assign carry_o     = r_carry;
    assign ovf_o       = r_ovf;

endmodule
